// File: rtl/alu_exec_ctrl_if.sv
// alu_exec_ctrl_if: bundles the op-request, alu-drive, alu-return and result signals of alu_exec_ctrl
// slave: controller side (receives ops and alu results, drives alu operands and results)
// master: environment side (issues ops, models the alu, consumes results)
interface alu_exec_ctrl_if #(parameter int DATA_W = 16);
  logic in_valid;
  logic in_ready;
  logic [3:0] in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0] alu_sel;
  logic [DATA_W-1:0] alu_out;
  logic alu_zero;
  logic alu_negative;
  logic res_valid;
  logic res_ready;
  logic [DATA_W-1:0] res_data;
  logic res_wr;
  logic branch_taken;
  logic illegal;
  logic flag_z;
  logic flag_n;
  modport slave (
    input in_valid, in_op, in_a, in_b, alu_out, alu_zero, alu_negative, res_ready,
    output in_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_wr, branch_taken, illegal, flag_z, flag_n
  );
  modport master (
    output in_valid, in_op, in_a, in_b, alu_out, alu_zero, alu_negative, res_ready,
    input in_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_wr, branch_taken, illegal, flag_z, flag_n
  );
endinterface

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: single-issue execute controller that sequences one op through an external alu
// ports: clk, rst (sync active-high), bus (alu_exec_ctrl_if.slave: op request, alu drive/return, result, flags)
module alu_exec_ctrl #(
  parameter int DATA_W = 16
) (
  input logic clk,
  input logic rst,
  alu_exec_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] STALL = 2'd3;
  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_STR = 4'b1000;
  localparam logic [3:0] OP_B = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1010;
  localparam logic [3:0] OP_BGE = 4'b1011;
  localparam logic [3:0] OP_STALL = 4'b1100;
  logic [1:0] state;
  logic [3:0] op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [3:0] cnt;
  logic [DATA_W-1:0] data_q;
  logic wr_q;
  logic br_q;
  logic ill_q;
  logic fz_q;
  logic fn_q;
  logic [DATA_W-1:0] data_d;
  logic wr_d;
  logic br_d;
  logic ill_d;
  logic flag_upd;
  always_comb begin
    data_d = op_q <= OP_STR ? bus.alu_out : op_q <= OP_BGE ? b_q : '0;
    wr_d = op_q inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b0111};
    // branches resolve against the flags as they stand before this op
    br_d = (op_q == OP_B) | ((op_q == OP_BEQ) & fz_q) | ((op_q == OP_BGE) & ~fn_q);
    ill_d = op_q > OP_STALL;
    flag_upd = op_q <= OP_CMP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      cnt <= '0;
      data_q <= '0;
      wr_q <= 1'b0;
      br_q <= 1'b0;
      ill_q <= 1'b0;
      fz_q <= 1'b0;
      fn_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op_q <= bus.in_op;
          a_q <= bus.in_a;
          b_q <= bus.in_b;
          if (bus.in_op == OP_STALL) begin
            cnt <= bus.in_a[3:0] == 4'd0 ? 4'd1 : bus.in_a[3:0];
            state <= STALL;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          data_q <= data_d;
          wr_q <= wr_d;
          br_q <= br_d;
          ill_q <= ill_d;
          if (flag_upd) begin
            fz_q <= bus.alu_zero;
            fn_q <= bus.alu_negative;
          end
          state <= RESP;
        end
        RESP: if (bus.res_ready) state <= IDLE;
        default: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= IDLE;
        end
      endcase
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.res_valid = state == RESP;
  assign bus.alu_a = a_q;
  assign bus.alu_b = b_q;
  assign bus.alu_sel = op_q;
  assign bus.res_data = data_q;
  assign bus.res_wr = wr_q;
  assign bus.branch_taken = br_q;
  assign bus.illegal = ill_q;
  assign bus.flag_z = fz_q;
  assign bus.flag_n = fn_q;
endmodule

// File: doc/alu_exec_ctrl.md
ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 SHALL have parameter: DATA_W, 16, operand and result width; alu_sel width is fixed at 4.
REQ-002 SHALL have port: clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: in_valid  in  1; in_ready  out  1  op-request handshake.
REQ-005 SHALL have ports: in_op  in  4  opcode; in_a  in  DATA_W  operand A; in_b  in  DATA_W  operand B or branch target.
REQ-006 SHALL have ports: alu_a  out  DATA_W; alu_b  out  DATA_W; alu_sel  out  4  drive to the alu block.
REQ-007 SHALL have ports: alu_out  in  DATA_W; alu_zero  in  1; alu_negative  in  1  returned by the alu block.
REQ-008 SHALL have ports: res_valid  out  1; res_ready  in  1  result handshake.
REQ-009 SHALL have ports: res_data  out  DATA_W; res_wr  out  1  register-write enable; branch_taken  out  1; illegal  out  1.
REQ-010 SHALL have ports: flag_z  out  1; flag_n  out  1  architectural flags.

Function
REQ-011 SHALL decode opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 LSL, 0101 CMP, 0110 SET, 0111 LDR, 1000 STR, 1001 B, 1010 BEQ, 1011 BGE, 1100 STALL, 1101-1111 illegal.
REQ-012 SHALL implement FSM states IDLE, EXEC, RESP, STALL; in_ready=1 only in IDLE.
REQ-013 SHALL, in IDLE with in_valid=1, latch in_op/in_a/in_b and go to STALL if op=1100, otherwise to EXEC.
REQ-014 SHALL drive alu_a/alu_b/alu_sel from the latched registers at all times; they do not change outside an accept edge.
REQ-015 SHALL, in EXEC (exactly one cycle), capture result fields at the clock edge and go to RESP; res_valid is high in the cycle 2 clocks after the accept edge.
REQ-016 SHALL hold res_valid and all result fields stable in RESP until res_valid and res_ready are both high, then go to IDLE; back-to-back acceptance in RESP is not supported.
REQ-017 SHALL set res_data: alu_out for ops 0000-1000; latched in_b for 1001-1011; 0 for illegal.
REQ-018 SHALL set res_wr=1 for ADD, SUB, AND, OR, LSL, SET, and LDR; otherwise 0.
REQ-019 SHALL update flag_z<=alu_zero and flag_n<=alu_negative at the EXEC edge only for ops 0000-0101; all other ops leave the flags unchanged.
REQ-020 SHALL set branch_taken: B always 1; BEQ = flag_z; BGE = !flag_n; all other ops 0. The decision uses flag values held before the branch.
REQ-021 SHALL set illegal=1 for opcodes 1101-1111, with res_wr=0, branch_taken=0, and no flag update.
REQ-022 SHALL, for STALL, load a counter with in_a[3:0] (0 treated as 1), remain in STALL for that many cycles, produce no res_valid, and return to IDLE.
REQ-023 SHALL ignore in_valid outside IDLE and ignore res_ready outside RESP.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, go to IDLE and clear to 0: res_valid, res_data, res_wr, branch_taken, illegal, flag_z, flag_n, alu_a, alu_b, alu_sel, and the stall counter.
REQ-025 SHALL give rst priority over all handshakes. Reset in EXEC, RESP, or STALL discards the pending operation; in_ready=1 in the cycle after reset.

Verification
REQ-026 SHALL pass: ADD a=0x0005 b=0x000A, alu_out=0x000F -> res_valid 2 cycles after accept, res_data=0x000F, res_wr=1, flag_z=0, flag_n=0.
REQ-027 SHALL pass: CMP a=b=0x000A with alu_zero=1, then BEQ b=0x0040 -> CMP gives res_wr=0 and flag_z=1; BEQ gives branch_taken=1, res_data=0x0040, flags unchanged.
REQ-028 SHALL pass: SUB a=0x0005 b=0x000A with alu_negative=1, then BGE b=0x0010 -> flag_n=1; BGE gives branch_taken=0.
REQ-029 SHALL pass: res_ready held low 3 cycles in RESP -> res_valid=1 and res_data stable for all 3 cycles; in_ready=0; IDLE in the cycle after the handshake.
REQ-030 SHALL pass: STALL a=0x0003 -> in_ready=0 for exactly 3 cycles, no res_valid; STALL a=0x0000 -> in_ready=0 for 1 cycle.
REQ-031 SHALL pass: opcode 1110, then rst asserted during RESP of an OR -> first gives illegal=1 with flags unchanged; after reset res_valid=0, flag_z=0, flag_n=0, in_ready=1.
